// File: rtl/rename_pkg.sv
// Shared definitions for the register-rename controller.
// Holds the default physical register count, the tag width and the recovery FSM states.
package rename_pkg;

  localparam int NUM_PHYS = 32;
  localparam int PREG_W   = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RESTORE = 2'd2
  } rename_state_e;

endpackage

// File: rtl/free_pick.sv
// Lowest-set-bit picker used to choose the next free physical tag.
// found is high when any bit of vec is set; index is the lowest set position (0 when none).
module free_pick #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    found = |vec;
    index = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      index = vec[i] ? W'(i) : index;
    end
  end

endmodule

// File: rtl/rename_ctrl_chk.sv
// Simulation checks for the rename controller: no double release of a physical tag,
// and p0 never appears in either free vector.
module rename_ctrl_chk #(
  parameter int NUM_PHYS = 32,
  parameter int PREG_W   = 5
) (
  input logic                clk,
  input logic                reset,
  input logic                commit_valid,
  input logic [PREG_W-1:0]   commit_old_phys,
  input logic [NUM_PHYS-1:0] arch_free,
  input logic                spec_bit0,
  input logic                arch_bit0
);

  // A released tag must currently be architecturally live (not already free).
  a_no_double_release: assert property (
    @(posedge clk) disable iff (reset)
    (commit_valid && (commit_old_phys != {PREG_W{1'b0}})) |-> !arch_free[commit_old_phys]
  );

  // p0 is permanently bound to r0 and must never be marked free.
  a_p0_never_free: assert property (
    @(posedge clk) disable iff (reset)
    !spec_bit0 && !arch_bit0
  );

endmodule

// File: rtl/rename_ctrl.sv
// Register-rename free-list controller.
// Hands out physical tags to decoded instructions, returns tags on commit, and
// rebuilds the speculative free list from the architectural one on flush
// (RUN -> FLUSH -> RESTORE -> RUN).
// Optional feature macro: RENAME_CTRL_STATS_EN adds saturating stall_cycles and
// alloc_total counters as extra outputs.
module rename_ctrl #(
  parameter int NUM_PHYS  = rename_pkg::NUM_PHYS,
  parameter int PREG_W    = rename_pkg::PREG_W,
  parameter int LOW_WATER = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic              dec_has_dest,
  input  logic [4:0]        dec_dest_arch,
  output logic              dec_ready,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_phys,
  input  logic              commit_valid,
  input  logic [PREG_W-1:0] commit_new_phys,
  input  logic [PREG_W-1:0] commit_old_phys,
  input  logic              flush_req,
  output logic              rat_restore,
  output logic [PREG_W:0]   free_count,
  output logic              low_free
`ifdef RENAME_CTRL_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       alloc_total
`endif
);

  import rename_pkg::*;

  localparam logic [NUM_PHYS-1:0] ONE_V  = {{(NUM_PHYS-1){1'b0}}, 1'b1};
  localparam logic [NUM_PHYS-1:0] INIT_V = ~ONE_V;
  localparam logic [PREG_W:0]     CNT_ZERO = {(PREG_W+1){1'b0}};
  localparam logic [PREG_W:0]     CNT_FULL = (PREG_W+1)'(NUM_PHYS - 1);
  localparam logic [PREG_W:0]     CNT_LOW  = (PREG_W+1)'(LOW_WATER);

  rename_state_e       state_r, state_s;
  logic [NUM_PHYS-1:0] spec_free_r, spec_free_s;
  logic [NUM_PHYS-1:0] arch_free_r, arch_free_s;
  logic [PREG_W:0]     free_count_r;
  logic                low_free_r;
  logic                rat_restore_r;

  logic                need_s, ready_s, fire_s, alloc_s;
  logic                pick_found_s;
  logic [PREG_W-1:0]   pick_idx_s;
  logic [NUM_PHYS-1:0] alloc_mask_s, rel_mask_s, new_mask_s;
  logic [PREG_W:0]     pop_next_s;

  function automatic logic [PREG_W:0] popcnt(input logic [NUM_PHYS-1:0] v);
    logic [PREG_W:0] c;
    c = {(PREG_W+1){1'b0}};
    for (int i = 0; i < NUM_PHYS; i++) begin
      c = c + {{PREG_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  free_pick #(
    .N (NUM_PHYS),
    .W (PREG_W)
  ) u_pick (
    .vec   (spec_free_r),
    .found (pick_found_s),
    .index (pick_idx_s)
  );

  // Decode handshake, same-cycle tag issue and commit masks.
  always_comb begin
    need_s       = dec_has_dest && (dec_dest_arch != 5'd0);
    ready_s      = !reset && (state_r == RUN) && !flush_req &&
                   (!need_s || (free_count_r != CNT_ZERO));
    fire_s       = dec_valid && ready_s;
    alloc_s      = fire_s && need_s && pick_found_s;
    alloc_mask_s = {NUM_PHYS{1'b0}};
    alloc_phys   = {PREG_W{1'b0}};
    new_mask_s   = {NUM_PHYS{1'b0}};
    rel_mask_s   = {NUM_PHYS{1'b0}};
    if (alloc_s) begin
      alloc_mask_s = ONE_V << pick_idx_s;
      alloc_phys   = pick_idx_s;
    end else begin
      alloc_mask_s = {NUM_PHYS{1'b0}};
      alloc_phys   = {PREG_W{1'b0}};
    end
    if (commit_valid) begin
      new_mask_s = ONE_V << commit_new_phys;
      if (commit_old_phys != {PREG_W{1'b0}}) begin
        rel_mask_s = ONE_V << commit_old_phys;
      end else begin
        rel_mask_s = {NUM_PHYS{1'b0}};
      end
    end else begin
      new_mask_s = {NUM_PHYS{1'b0}};
      rel_mask_s = {NUM_PHYS{1'b0}};
    end
    dec_ready   = ready_s;
    alloc_valid = alloc_s;
  end

  // Recovery FSM next state and next contents of both free vectors.
  always_comb begin
    state_s     = state_r;
    arch_free_s = ((arch_free_r & ~new_mask_s) | rel_mask_s) & ~ONE_V;
    spec_free_s = spec_free_r;
    case (state_r)
      RUN: begin
        spec_free_s = (spec_free_r & ~alloc_mask_s) | rel_mask_s;
        state_s     = flush_req ? FLUSH : RUN;
      end
      FLUSH: begin
        // Reload from the architectural view, including this cycle's commit.
        spec_free_s = arch_free_s;
        state_s     = flush_req ? FLUSH : RESTORE;
      end
      RESTORE: begin
        spec_free_s = spec_free_r | rel_mask_s;
        state_s     = flush_req ? FLUSH : RUN;
      end
      default: begin
        spec_free_s = spec_free_r | rel_mask_s;
        state_s     = RUN;
      end
    endcase
    spec_free_s = spec_free_s & ~ONE_V;
    pop_next_s  = popcnt(spec_free_s);
  end

  // State, free vectors and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      spec_free_r   <= INIT_V;
      arch_free_r   <= INIT_V;
      free_count_r  <= CNT_FULL;
      low_free_r    <= 1'b0;
      rat_restore_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      spec_free_r   <= spec_free_s;
      arch_free_r   <= arch_free_s;
      free_count_r  <= pop_next_s;
      low_free_r    <= (pop_next_s <= CNT_LOW);
      rat_restore_r <= (state_s == RESTORE);
    end
  end

  assign free_count  = free_count_r;
  assign low_free    = low_free_r;
  assign rat_restore = rat_restore_r;

`ifdef RENAME_CTRL_STATS_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] alloc_cnt_r;

  // Saturating counters for pool-empty stalls and issued tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      alloc_cnt_r <= 16'd0;
    end else begin
      if (dec_valid && need_s && (state_r == RUN) && (free_count_r == CNT_ZERO) &&
          (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (alloc_s && (alloc_cnt_r != 16'hFFFF)) begin
        alloc_cnt_r <= alloc_cnt_r + 16'd1;
      end else begin
        alloc_cnt_r <= alloc_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign alloc_total  = alloc_cnt_r;
`endif

  rename_ctrl_chk #(
    .NUM_PHYS (NUM_PHYS),
    .PREG_W   (PREG_W)
  ) u_chk (
    .clk             (clk),
    .reset           (reset),
    .commit_valid    (commit_valid),
    .commit_old_phys (commit_old_phys),
    .arch_free       (arch_free_r),
    .spec_bit0       (spec_free_r[0]),
    .arch_bit0       (arch_free_r[0])
  );

endmodule
